// File: rtl/calc_ndigit_pkg.sv
// Shared command codes, status codes and FSM states for the N-digit calculator.
package calc_pkg;
    localparam logic [3:0] CMD_ADD = 4'd10;
    localparam logic [3:0] CMD_SUB = 4'd11;
    localparam logic [3:0] CMD_MUL = 4'd12;
    localparam logic [3:0] CMD_DIV = 4'd13;
    localparam logic [3:0] CMD_EQ  = 4'd14;
    localparam logic [3:0] CMD_BS  = 4'd15;

    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    typedef enum logic [2:0] {
        ENTRY_A, ENTRY_B, COMPUTE, CONVERT, SCAN, ERROR
    } state_t;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction
endpackage

// File: rtl/calc_ndigit_if.sv
// Keypad command handshake between the keypad decoder and the calculator.
interface calc_ndigit_if;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;

    modport master (output cmd, output cmd_valid, input cmd_ready);
    modport slave  (input cmd, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/calc_bin2bcd.sv
// Sequential double-dabble: the start cycle shifts in the first bit, W-1 more follow.
module calc_bin2bcd #(
    parameter int W    = 27,
    parameter int NDIG = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [W-1:0]        bin,
    output logic                done,
    output logic [4*NDIG-1:0]   bcd
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]      sr;
    logic [4*NDIG-1:0] adj;
    logic [CW-1:0]     cnt;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NDIG; i++)
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    // Reset behaves like a start on a zero value so the power-up scan
    // lines up with the first W cycles after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sr  <= '0;
            bcd <= '0;
            cnt <= CW'(W - 1);
        end else if (start) begin
            sr  <= {bin[W-2:0], 1'b0};
            bcd <= (4*NDIG)'(bin[W-1]);
            cnt <= CW'(W - 1);
        end else if (cnt != '0) begin
            sr  <= {sr[W-2:0], 1'b0};
            bcd <= {adj[4*NDIG-2:0], sr[W-1]};
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);
endmodule

// File: rtl/calc_ndigit.sv
// N-digit decimal calculator: keypad entry, add/sub, iterative mul/div, BCD display scan.
module calc_ndigit
    import calc_pkg::*;
#(
    parameter int NDIG = 8,
    parameter int W    = 27
) (
    input  logic                      clock,
    input  logic                      reset,
    calc_ndigit_if.slave              bus,
    output logic [1:0]                status,
    output logic [W-1:0]              digits,
    output logic                      neg,
    output logic [$clog2(NDIG)-1:0]   pos,
    output logic [3:0]                data
);
    localparam logic [W-1:0] MAX = W'(pow10(NDIG) - 64'd1);
    localparam int CW = $clog2(W + 1);

    state_t                  state, state_n, ret, ret_n;
    logic [W-1:0]            a, a_n, b, b_n, q, q_n, q_s, digits_n;
    logic [3:0]              op, op_n, data_n;
    logic                    neg_n, conv_start, conv_start_n, conv_done;
    logic                    accept, go_conv, go_err, sub_ok;
    logic [$clog2(NDIG)-1:0] pos_n;
    logic [CW-1:0]           ccnt, ccnt_n;
    logic [2*W-1:0]          acc, acc_n, acc_s, mcand, mcand_n;
    logic [NDIG-1:0][3:0]    bcd;
    logic [W+3:0]            ext;
    logic [W:0]              sum, r_sh, rem;

    calc_bin2bcd #(.W(W), .NDIG(NDIG)) u_bcd (
        .clock (clock),
        .reset (reset),
        .start (conv_start),
        .bin   (digits),
        .done  (conv_done),
        .bcd   (bcd)
    );

    always_comb begin
        case (state)
            ERROR:            status = ST_ERR;
            ENTRY_A, ENTRY_B: status = ST_READY;
            default:          status = ST_BUSY;
        endcase
    end

    assign bus.cmd_ready = (state == ENTRY_A) || (state == ENTRY_B);
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    // One mul (LSB-first shift-add) or restoring-div step; acc low bits hold the remainder.
    always_comb begin
        acc_s  = acc;
        q_s    = q;
        r_sh   = '0;
        rem    = '0;
        sub_ok = 1'b0;
        if (op == CMD_MUL) begin
            if (q[0]) acc_s = acc + mcand;
            q_s = q >> 1;
        end else begin
            r_sh   = {acc[W-1:0], q[W-1]};
            sub_ok = (r_sh >= {1'b0, b});
            rem    = sub_ok ? r_sh - {1'b0, b} : r_sh;
            q_s    = {q[W-2:0], sub_ok};
            acc_s  = (2*W)'(rem);
        end
    end

    always_comb begin
        state_n      = state;
        ret_n        = ret;
        digits_n     = digits;
        neg_n        = neg;
        a_n          = a;
        b_n          = b;
        op_n         = op;
        q_n          = q;
        acc_n        = acc;
        mcand_n      = mcand;
        ccnt_n       = ccnt;
        pos_n        = pos;
        data_n       = data;
        conv_start_n = 1'b0;
        go_conv      = 1'b0;
        go_err       = 1'b0;
        ext = (W+4)'(digits) * (W+4)'(10) + (W+4)'(bus.cmd);
        sum = {1'b0, a} + {1'b0, digits};

        case (state)
            ENTRY_A, ENTRY_B: if (accept) begin
                if (bus.cmd <= 4'd9) begin
                    if (ext <= (W+4)'(MAX)) begin
                        digits_n = ext[W-1:0];
                        neg_n    = 1'b0;
                        ret_n    = state;
                        go_conv  = 1'b1;
                    end
                end else if (bus.cmd == CMD_BS) begin
                    digits_n = digits / W'(10);
                    ret_n    = state;
                    go_conv  = 1'b1;
                end else if (bus.cmd == CMD_EQ) begin
                    if (state == ENTRY_B) begin
                        b_n   = digits;
                        ret_n = ENTRY_A;
                        case (op)
                            CMD_ADD: begin
                                go_err   = (sum > {1'b0, MAX});
                                go_conv  = !go_err;
                                digits_n = sum[W-1:0];
                                neg_n    = 1'b0;
                            end
                            CMD_SUB: begin
                                neg_n    = (a < digits);
                                digits_n = (a < digits) ? digits - a : a - digits;
                                go_conv  = 1'b1;
                            end
                            CMD_MUL: begin
                                acc_n   = '0;
                                mcand_n = (2*W)'(a);
                                q_n     = digits;
                                ccnt_n  = '0;
                                state_n = COMPUTE;
                            end
                            default: begin
                                if (digits == '0) go_err = 1'b1;
                                else begin
                                    acc_n   = '0;
                                    q_n     = a;
                                    ccnt_n  = '0;
                                    state_n = COMPUTE;
                                end
                            end
                        endcase
                    end
                end else if (state == ENTRY_A) begin
                    a_n      = digits;
                    op_n     = bus.cmd;
                    digits_n = '0;
                    ret_n    = ENTRY_B;
                    go_conv  = 1'b1;
                end else begin
                    go_err = 1'b1;
                end
            end
            COMPUTE: begin
                acc_n   = acc_s;
                q_n     = q_s;
                mcand_n = mcand << 1;
                ccnt_n  = ccnt + 1'b1;
                if (ccnt == CW'(W - 1)) begin
                    if (op == CMD_MUL && acc_s > (2*W)'(MAX)) go_err = 1'b1;
                    else begin
                        digits_n = (op == CMD_MUL) ? acc_s[W-1:0] : q_s;
                        neg_n    = 1'b0;
                        go_conv  = 1'b1;
                    end
                end
            end
            // conv_start guards against the previous conversion's stale done.
            CONVERT: if (conv_done && !conv_start) begin
                state_n = SCAN;
                pos_n   = '0;
                data_n  = bcd[0];
            end
            SCAN: begin
                if (int'(pos) == NDIG - 1) begin
                    state_n = ret;
                    pos_n   = '0;
                    data_n  = '0;
                end else begin
                    pos_n  = pos + 1'b1;
                    data_n = bcd[pos_n];
                end
            end
            default: ;
        endcase

        if (go_conv) begin
            state_n      = CONVERT;
            conv_start_n = 1'b1;
        end
        if (go_err) state_n = ERROR;
        if (state_n == ERROR) begin
            digits_n = '0;
            neg_n    = 1'b0;
            pos_n    = '0;
            data_n   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= CONVERT;
            ret        <= ENTRY_A;
            digits     <= '0;
            neg        <= 1'b0;
            a          <= '0;
            b          <= '0;
            op         <= '0;
            q          <= '0;
            acc        <= '0;
            mcand      <= '0;
            ccnt       <= '0;
            pos        <= '0;
            data       <= '0;
            conv_start <= 1'b0;
        end else begin
            state      <= state_n;
            ret        <= ret_n;
            digits     <= digits_n;
            neg        <= neg_n;
            a          <= a_n;
            b          <= b_n;
            op         <= op_n;
            q          <= q_n;
            acc        <= acc_n;
            mcand      <= mcand_n;
            ccnt       <= ccnt_n;
            pos        <= pos_n;
            data       <= data_n;
            conv_start <= conv_start_n;
        end
    end
endmodule

// File: doc/calc_ndigit.md
# calc_ndigit

Parametrised successor to the single-width decimal calculator. It takes a 4-bit keypad command stream through a valid/ready handshake and builds two decimal operands of up to NDIG digits. It performs add, subtract (signed result), multi-cycle multiply and multi-cycle divide, then scans the BCD result out one digit per cycle to the display driver. It sits between the keypad decoder and the 7-segment multiplexer.

## Interface
- NDIG, 8: number of decimal digits per operand/result; MAX = 10^NDIG−1.
- W, 27: binary operand width; must satisfy 2^W > MAX.
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- cmd  in  4  command: 0–9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 equals, 15 backspace.
- cmd_valid  in  1  cmd is presented.
- cmd_ready  out  1  block accepts cmd this cycle.
- status  out  2  00 error, 01 busy, 10 ready.
- digits  out  W  current binary value shown (operand being entered or result).
- neg  out  1  result is negative (sub only).
- pos  out  $clog2(NDIG)  display position being driven, 0 = least significant.
- data  out  4  BCD digit for position pos.

## Operation
- A command is accepted only on a cycle with cmd_valid && cmd_ready. cmd_ready = 1 only when status == 10 and state ∈ {ENTRY_A, ENTRY_B}.
- States:
  - ENTRY_A, ENTRY_B: operand entry.
  - COMPUTE: multi-cycle mul/div.
  - CONVERT: binary-to-BCD conversion.
  - SCAN: display refresh.
  - ERROR.
- Digit d in ENTRY_A/ENTRY_B:
  - If digits*10+d ≤ MAX: digits ← digits*10+d, neg ← 0, go CONVERT.
  - Otherwise the command is accepted and ignored, with status staying 10.
- Backspace: digits ← digits/10 (0 stays 0), go CONVERT.
- Operator (10–13) in ENTRY_A: A ← digits, op ← cmd, digits ← 0, go CONVERT, then ENTRY_B.
- Operator (10–13) in ENTRY_B: go ERROR.
- Equals in ENTRY_A: ignored.
- Equals in ENTRY_B: B ← digits, then:
  - add: r = A+B; r > MAX → ERROR.
  - sub: A ≥ B → r = A−B, neg 0; otherwise r = B−A, neg 1.
  - mul: shift-add over W cycles in COMPUTE, one multiplier bit per cycle, 2W-bit accumulator; result > MAX → ERROR.
  - div: restoring division over W cycles in COMPUTE; quotient only; B == 0 → ERROR immediately with no COMPUTE cycles.
- After a result, digits ← r and the return state is ENTRY_A, so the result chains as the next A.
- CONVERT: sub-module converts digits to NDIG BCD nibbles.
- SCAN: pos runs 0..NDIG−1, one per cycle, with data = BCD[pos]. Then pos ← 0, status ← 10, and the FSM enters the return state.
- ERROR: status 00, cmd_ready 0, digits 0, neg 0, data 0, pos 0. Held until reset; all commands are ignored.

## Timing
- Reset (synchronous, sampled on clock):
  - Outputs: status 01, cmd_ready 0, digits 0, neg 0, pos 0, data 0.
  - Internal: A, B, op cleared.
  - State CONVERT with return ENTRY_A. The block then scans a 0 and becomes ready.
- Acceptance at edge T: status = 01 and cmd_ready = 0 from T+1.
- Latency from acceptance to status == 10:
  - Entry, backspace, operator, add, sub: 1 + W + NDIG cycles.
  - mul, div: add W COMPUTE cycles.
- During SCAN, pos and data change together and are registered. data is 0 outside SCAN.
- Errors are detected at acceptance or at the end of COMPUTE. status = 00 appears the next cycle.
- Reset mid-COMPUTE/CONVERT/SCAN aborts the operation; the next cycle shows the reset values.
- When cmd_ready = 0, cmd_valid is ignored. No command is buffered.

## Structure
- Package calc_pkg holds:
  - Command constants: CMD_ADD=10, CMD_SUB=11, CMD_MUL=12, CMD_DIV=13, CMD_EQ=14, CMD_BS=15.
  - Status constants: ST_ERR=00, ST_BUSY=01, ST_READY=10.
  - State enum: ENTRY_A, ENTRY_B, COMPUTE, CONVERT, SCAN, ERROR.
- Sub-module calc_bin2bcd (params W, NDIG):
  - Sequential double-dabble, one bit per cycle.
  - Ports: start, bin[W], done, bcd[4*NDIG].
  - Latency W cycles from start to done.
- Mul/div datapath lives in the top module.

## Test plan
- Reset: status 01 for W+NDIG cycles, with pos 0..7 and data 0 during SCAN, then status 10 and cmd_ready 1.
- Keys 1,2,+,3,4,= → digits 46, neg 0; scan shows data 6,4,0,0,0,0,0,0; status 10.
- Keys 5,−,9,= → digits 4, neg 1. Then digit 7 → digits 47, neg 0.
- Keys 1,2,3,×,4,5,= → digits 5535 after W COMPUTE + W + NDIG cycles. Then ÷,5,= → 1107 (chaining).
- Keys 7,÷,0,= → status 00, cmd_ready 0 until reset. Separately, 99999999 then +,1,= → status 00.
- Keys 1..9 (nine digits) → digits 12345678, with the ninth accepted and ignored. Backspace ×9 → digits 0. cmd_valid held high while busy → nothing accepted.
